mips_dmem_responder: RTL

- Data-side responder for the pipelined MIPS core; consumes the core's MEM-stage `memaddr`, `memwrite` and `memwritedata`, and returns `memreaddata`.
- Contains a word-addressed data RAM and a small memory-mapped I/O region: a 32-bit timer with compare/match and a GPIO output register.
- Sits beside the instruction memory at the system level. It is the only consumer of the core's data bus.

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/mips_timer.sv | 92 +++++++++
 rtl/mips_dmem_responder.sv | 72 +++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS data-side responder: I/O base, register
// offsets and bit positions inside the timer control/status registers.
package mips_mem_pkg;

    // Default base byte address of the memory-mapped I/O window
    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    // Byte offsets of the I/O registers inside the window
    localparam logic [7:0] OFF_COUNT = 8'h00;
    localparam logic [7:0] OFF_CMP   = 8'h04;
    localparam logic [7:0] OFF_CTRL  = 8'h08;
    localparam logic [7:0] OFF_STAT  = 8'h0C;
    localparam logic [7:0] OFF_GPIO  = 8'h10;
    localparam logic [7:0] OFF_PRESC = 8'h14;

    // CTRL register layout
    localparam int CTRL_W       = 3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTOCLR = 1;
    localparam int CTRL_IRQEN   = 2;

    // STAT register layout
    localparam int STAT_MATCH = 0;

endpackage

// File: rtl/mips_timer.sv
// 32-bit timer with compare/match, optional auto-clear and interrupt enable.
// Build option: MIPS_DMEM_PRESCALER_EN adds a 16-bit PRESC register at 0x14
// and an internal prescale counter that gates timer evaluation.
module mips_timer
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [7:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0]       count;
    logic [31:0]       cmp;
    logic [CTRL_W-1:0] ctrl;
    logic              match;
    logic              tick;
    logic              hit;

`ifdef MIPS_DMEM_PRESCALER_EN
    logic [15:0] presc;
    logic [15:0] pcnt;

    assign tick = ctrl[CTRL_EN] && (pcnt == presc);

    // Prescaler: PRESC register and a counter that wraps on every tick, held clear while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            pcnt  <= '0;
        end else begin
            if (we && offset == OFF_PRESC)
                presc <= wdata[15:0];
            if (!ctrl[CTRL_EN] || pcnt == presc)
                pcnt <= '0;
            else
                pcnt <= pcnt + 16'd1;
        end
    end
`else
    assign tick = ctrl[CTRL_EN];
`endif

    // Compare always uses the COUNT value from before any core write this cycle
    assign hit = tick && (count == cmp);
    assign irq = match && ctrl[CTRL_IRQEN];

    // Timer registers: a core write to COUNT beats the increment, a match beats a W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            cmp   <= 32'hFFFF_FFFF;
            ctrl  <= '0;
            match <= 1'b0;
        end else begin
            if (we && offset == OFF_COUNT)
                count <= wdata;
            else if (tick)
                count <= (hit && ctrl[CTRL_AUTOCLR]) ? 32'd0 : count + 32'd1;

            if (we && offset == OFF_CMP)
                cmp <= wdata;

            if (we && offset == OFF_CTRL)
                ctrl <= wdata[CTRL_W-1:0];

            if (hit)
                match <= 1'b1;
            else if (we && offset == OFF_STAT && wdata[STAT_MATCH])
                match <= 1'b0;
        end
    end

    // Register read mux; reserved offsets read as zero
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_COUNT: rdata = count;
            OFF_CMP:   rdata = cmp;
            OFF_CTRL:  rdata = {{(32-CTRL_W){1'b0}}, ctrl};
            OFF_STAT:  rdata = {31'b0, match};
`ifdef MIPS_DMEM_PRESCALER_EN
            OFF_PRESC: rdata = {16'b0, presc};
`endif
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side responder for the pipelined MIPS core: word RAM, GPIO register and
// the timer block, with zero-latency reads and edge-committed stores.
// Build option: MIPS_DMEM_PRESCALER_EN (passed through to mips_timer).
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int          RAM_AW  = 6,
    parameter int          GPIO_W  = 16,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       memaddr,
    input  logic              memwrite,
    input  logic [31:0]       memwritedata,
    output logic [31:0]       memreaddata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    logic              ram_sel;
    logic              io_sel;
    logic [RAM_AW-1:0] word_idx;
    logic [7:0]        io_off;
    logic [31:0]       timer_rdata;
    logic [GPIO_W-1:0] gpio;
    logic [31:0]       ram [2**RAM_AW];

    // Accesses are whole-word; the byte lane bits are deliberately dropped
    wire unused_lsb = &{1'b0, memaddr[1:0]};

    assign ram_sel  = (memaddr[31:RAM_AW+2] == '0);
    assign io_sel   = (memaddr[31:8] == IO_BASE[31:8]);
    assign word_idx = memaddr[RAM_AW+1:2];
    assign io_off   = {memaddr[7:2], 2'b00};
    assign gpio_out = gpio;

    // Data RAM: no reset, contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (memwrite && ram_sel)
            ram[word_idx] <= memwritedata;
    end

    // GPIO output register, low GPIO_W bits of the store data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gpio <= '0;
        else if (memwrite && io_sel && io_off == OFF_GPIO)
            gpio <= memwritedata[GPIO_W-1:0];
    end

    mips_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .we     (memwrite && io_sel),
        .offset (io_off),
        .wdata  (memwritedata),
        .rdata  (timer_rdata),
        .irq    (timer_irq)
    );

    // Combinational read mux so the core can capture load data at the MEM/WB edge
    always_comb begin
        memreaddata = '0;
        if (ram_sel)
            memreaddata = ram[word_idx];
        else if (io_sel)
            memreaddata = (io_off == OFF_GPIO) ? {{(32-GPIO_W){1'b0}}, gpio} : timer_rdata;
    end

endmodule
